// File: rtl/instr_fetch_if.sv
// Instruction-memory handshake between the fetch stage (master) and imem (slave).
// Signal names carry the fetch stage's direction suffixes so traces read the same on both sides.
interface instr_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    // imem_data_i is valid for imem_addr_o only in a cycle where imem_ready_i is high;
    // the memory answers only for the address presented in that same cycle.
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC register, imem request, one-entry hold buffer and IF/ID register.
// Redirect/flush beat stall; a word returned while stalled parks in the hold buffer.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    instr_fetch_if.master        imem,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_plus4_o,
    output logic                 valid_o,
    output logic                 fsm_state_o
);
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_plus4_q, hold_pc_plus4_d;

    logic [31:0] pc_seq;
    logic        eff_stall;
    logic        unused_redirect_lsbs;

    assign pc_seq               = pc_q + 32'd4;
    assign eff_stall            = stall_i && !flush_i;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        pc_plus4_d      = pc_plus4_q;
        valid_d         = valid_q;
        hold_instr_d    = hold_instr_q;
        hold_pc_plus4_d = hold_pc_plus4_q;

        if (redirect_i) begin
            // Returned word and any parked word are dropped by simply returning to FETCH.
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            state_d = S_FETCH;
            if (flush_i || !stall_i) begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
            end
        end else begin
            if (state_q == S_FETCH) begin
                if (imem.imem_ready_i) begin
                    pc_d = pc_seq;
                    if (eff_stall) begin
                        hold_instr_d    = imem.imem_data_i;
                        hold_pc_plus4_d = pc_seq;
                        state_d         = S_HOLD;
                    end else begin
                        instr_d    = imem.imem_data_i;
                        pc_plus4_d = pc_seq;
                        valid_d    = 1'b1;
                    end
                end else if (!eff_stall) begin
                    instr_d    = 32'h0;
                    pc_plus4_d = 32'h0;
                    valid_d    = 1'b0;
                end
            end else if (!eff_stall) begin
                instr_d    = hold_instr_q;
                pc_plus4_d = hold_pc_plus4_q;
                valid_d    = 1'b1;
                state_d    = S_FETCH;
            end

            // A flush overrides whatever would have entered IF/ID this cycle.
            if (flush_i) begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_FETCH;
            pc_q            <= {RESET_PC[31:2], 2'b00};
            instr_q         <= 32'h0;
            pc_plus4_q      <= 32'h0;
            valid_q         <= 1'b0;
            hold_instr_q    <= 32'h0;
            hold_pc_plus4_q <= 32'h0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            pc_plus4_q      <= pc_plus4_d;
            valid_q         <= valid_d;
            hold_instr_q    <= hold_instr_d;
            hold_pc_plus4_q <= hold_pc_plus4_d;
        end
    end

    assign imem.imem_req_o  = (state_q == S_FETCH) && !rst_i;
    assign imem.imem_addr_o = pc_q;
    assign instr_o          = instr_q;
    assign pc_plus4_o       = pc_plus4_q;
    assign valid_o          = valid_q;
    assign fsm_state_o      = (state_q == S_HOLD);
endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Fetch stage of the pipelined MIPS datapath.
- Holds the PC and drives the instruction-memory handshake.
- Produces the IF/ID register that supplies the opcode field to the control decoder and the PC+4 value to branch/jump target logic.
- Accepts stall and flush from the hazard unit and redirect targets from branch/jump resolution.

## Interface

- RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- stall_i  input  1  hold PC and IF/ID contents (load-use hazard).
- flush_i  input  1  replace IF/ID contents with a bubble (taken branch/jump in ID/EX).
- redirect_i  input  1  load redirect_pc_i as the next fetch address.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 00.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  fetch address (current PC).
- imem_ready_i  input  1  imem_data_i valid for imem_addr_o this cycle.
- imem_data_i  input  32  instruction word.
- instr_o  output  32  IF/ID instruction; [31:26] is the decoder opcode input.
- pc_plus4_o  output  32  IF/ID PC+4 of instr_o.
- valid_o  output  1  IF/ID holds a real instruction; 0 means bubble and instr_o = 32'h0 (sll $0,$0,0, decodes as R-type nop).

## Operation

- State machine, two states:
  - FETCH: imem_req_o=1, imem_addr_o=pc.
  - HOLD: imem_req_o=0, one-entry hold buffer occupied.
- FETCH, imem_ready_i=1, stall_i=0:
  - IF/ID <= {imem_data_i, pc+4}, valid_o <= 1.
  - pc <= pc+4.
- FETCH, imem_ready_i=1, stall_i=1:
  - hold buffer <= {imem_data_i, pc+4}.
  - pc <= pc+4.
  - Go to HOLD; IF/ID unchanged.
- FETCH, imem_ready_i=0, stall_i=0: IF/ID <= bubble.
- FETCH, imem_ready_i=0, stall_i=1: IF/ID unchanged.
- HOLD, stall_i=1: everything unchanged.
- HOLD, stall_i=0: IF/ID <= hold buffer, valid_o <= 1, go to FETCH.
- Priority per cycle: rst_i > redirect_i/flush_i > stall_i > normal operation.
- redirect_i=1:
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - Any word returned this cycle and any hold-buffer contents are discarded.
  - Next state is FETCH.
  - IF/ID follows flush_i/stall_i; without flush and without stall it becomes a bubble.
- flush_i=1: IF/ID <= bubble, even if stall_i=1. Without redirect_i, PC/state/buffer still follow the rules above with stall_i treated as 0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. pc[1:0] is always 00.
- imem_addr_o may change while a request is pending; memory responds only for the address presented in the same cycle.

## Timing

- Reset (rst_i=1 at an edge), values after that edge:
  - pc = RESET_PC, state = FETCH.
  - instr_o = 0, pc_plus4_o = 0, valid_o = 0.
  - Hold buffer empty.
  - imem_req_o = 0 while rst_i is high.
- Reset mid-operation discards held and in-flight instructions with no partial update.
- Latency: word accepted at edge N (ready=1, stall=0) appears on instr_o/valid_o after edge N. With zero-wait memory, throughput is one instruction per cycle.
- Redirect at edge N: imem_addr_o = target from edge N onward. First target instruction reaches IF/ID one edge after it is accepted.
- Stall release from HOLD has zero added bubbles: buffer enters IF/ID at the release edge, and fetch resumes at the already-advanced PC.
- imem_req_o, imem_addr_o are registered-state outputs with no combinational path from stall_i/flush_i/redirect_i.

## Test plan

- Reset then zero-wait memory returning addr-tagged words:
  - instr_o sequence for PCs 0,4,8,12 on consecutive cycles.
  - pc_plus4_o = 4,8,12,16.
  - valid_o=1 from the second edge after reset.
- Wait states, ready low 2 cycles per word: two bubbles (valid_o=0, instr_o=0) between instructions; imem_addr_o constant while waiting.
- stall_i high 3 cycles while a word returns:
  - FSM enters HOLD, imem_req_o=0, IF/ID frozen.
  - On release, held word appears with no lost or duplicated instruction.
- redirect_i with redirect_pc_i=32'h0000_0103 plus flush_i, both during HOLD:
  - Buffer dropped, IF/ID bubble.
  - Next imem_addr_o = 32'h0000_0100.
  - Next valid instruction has pc_plus4_o = 32'h0000_0104.
- flush_i and stall_i together: IF/ID becomes bubble; PC advances if the word was accepted.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_o wraps to 0 and then 4. rst_i asserted mid-stream returns the PC to RESET_PC and clears valid_o.
